// File: rtl/tlm_pkg.sv
// Shared types, default constants and sizing helper for the telemetry bit buffer.
package tlm_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_CAPT = 2'd1,
    W_CLR  = 2'd2
  } wr_state_e;

  localparam int unsigned TLM_CLK_HZ = 32'd100_000_000;
  localparam int unsigned TLM_BAUD   = 32'd1200;
  localparam logic [7:0]  TLM_IDLE   = 8'h7E;

  // Ceiling log2, never below 1 so the result can size a vector directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 32'd0;
    while ((64'd1 << res) < {32'd0, value}) begin
      res = res + 32'd1;
    end
    return (res == 32'd0) ? 32'd1 : res;
  endfunction

endpackage

// File: rtl/tlm_fifo.sv
// Synchronous word FIFO; the head word is held in a register (first-word fall-through).
module tlm_fifo
  import tlm_pkg::*;
#(
  parameter int unsigned  DATA_W  = 8,
  parameter int unsigned  DEPTH_W = 1280,
  localparam int unsigned LVL_W   = clog2(DEPTH_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = clog2(DEPTH_W);

  logic [DATA_W-1:0] mem_q [DEPTH_W];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              full_q, empty_q;
  logic              push_ok_s, pop_ok_s;

  // Pointers wrap at DEPTH_W-1 explicitly, since the depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH_W - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  always_comb begin
    push_ok_s = push && (!full_q || pop);
    pop_ok_s  = pop && !empty_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    lvl_d     = lvl_q;
    dout_d    = dout_q;
    if (push_ok_s) wr_d = ptr_inc(wr_q);
    else           wr_d = wr_q;
    if (pop_ok_s) rd_d = ptr_inc(rd_q);
    else          rd_d = rd_q;
    if (push_ok_s && !pop_ok_s)      lvl_d = lvl_q + LVL_W'(1);
    else if (pop_ok_s && !push_ok_s) lvl_d = lvl_q - LVL_W'(1);
    else                             lvl_d = lvl_q;
    // Incoming word becomes the head when the FIFO is (or is about to be) empty.
    if (push_ok_s && (empty_q || (pop_ok_s && lvl_q == LVL_W'(1)))) dout_d = din;
    else if (pop_ok_s && lvl_q > LVL_W'(1))                          dout_d = mem_q[rd_d];
    else                                                             dout_d = dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= PTR_W'(0);
      rd_q    <= PTR_W'(0);
      lvl_q   <= LVL_W'(0);
      dout_q  <= DATA_W'(0);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      dout_q  <= dout_d;
      full_q  <= (lvl_d == LVL_W'(DEPTH_W));
      empty_q <= (lvl_d == LVL_W'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_q] <= din;
  end

  assign dout  = dout_q;
  assign level = lvl_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/tlm_bitbuf.sv
// Telemetry receive buffer: captures receiver words into a FIFO and streams them out
// serially at a fixed bit rate, with idle fill, watermark and overflow counting.
module tlm_bitbuf
  import tlm_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       DEPTH_W   = 1280,
  parameter int unsigned       CLK_DIV   = TLM_CLK_HZ / TLM_BAUD,
  parameter int unsigned       LSB_FIRST = 1,
  parameter int unsigned       AFULL_LVL = 1024,
  parameter logic [DATA_W-1:0] IDLE_PAT  = DATA_W'(TLM_IDLE),
  localparam int unsigned      LVL_W     = clog2(DEPTH_W + 1)
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic [DATA_W-1:0] rbr,
  input  logic              rdrdy,
  output logic              rdrst,
  input  logic              fill_en,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_fill,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic [15:0]       ovf_cnt
);

  localparam int unsigned DIV_W = clog2(CLK_DIV);
  localparam int unsigned IDX_W = clog2(DATA_W);

  wr_state_e         state_q, state_d;
  logic              rdrst_q, capt_s, push_s, pop_s, tick_s, load_s;
  logic [15:0]       ovf_q, ovf_d;
  logic              afull_q;
  logic [LVL_W-1:0]  lvl_nxt_s;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d, word_s, fifo_dout_s;
  logic              bout_q, bout_d, bv_q, bv_d, fill_q, fill_d;
  logic              fifo_full_s, fifo_empty_s;

  tlm_fifo #(
    .DATA_W (DATA_W),
    .DEPTH_W(DEPTH_W)
  ) u_fifo (
    .clk  (clk_100M),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .din  (rbr),
    .dout (fifo_dout_s),
    .level(level),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  always_comb begin
    state_d = state_q;
    capt_s  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (rdrdy) state_d = W_CAPT;
        else       state_d = W_IDLE;
      end
      W_CAPT: begin
        capt_s  = 1'b1;
        state_d = W_CLR;
      end
      W_CLR: begin
        if (!rdrdy) state_d = W_IDLE;
        else        state_d = W_CLR;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // A full FIFO still accepts the word when the serialiser pops in the same cycle.
  assign push_s = capt_s && (!fifo_full_s || pop_s);

  always_comb begin
    ovf_d = ovf_q;
    if (capt_s && !push_s && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
    else                                          ovf_d = ovf_q;
  end

  assign tick_s = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d = div_q;
    if (tick_s) div_d = DIV_W'(0);
    else        div_d = div_q + DIV_W'(1);
  end

  always_comb begin
    pop_s  = 1'b0;
    load_s = 1'b0;
    word_s = sh_q;
    sh_d   = sh_q;
    idx_d  = idx_q;
    bout_d = bout_q;
    bv_d   = 1'b0;
    fill_d = fill_q;
    if (tick_s && idx_q == IDX_W'(0)) begin
      if (!fifo_empty_s) begin
        pop_s  = 1'b1;
        load_s = 1'b1;
        word_s = fifo_dout_s;
        fill_d = 1'b0;
      end else if (fill_en) begin
        load_s = 1'b1;
        word_s = IDLE_PAT;
        fill_d = 1'b1;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
    // A started word (data or fill) always runs to its last bit.
    if (tick_s && (load_s || idx_q != IDX_W'(0))) begin
      bv_d = 1'b1;
      if (LSB_FIRST != 32'd0) begin
        bout_d = word_s[0];
        sh_d   = {1'b0, word_s[DATA_W-1:1]};
      end else begin
        bout_d = word_s[DATA_W-1];
        sh_d   = {word_s[DATA_W-2:0], 1'b0};
      end
      if (idx_q == IDX_W'(DATA_W - 1)) idx_d = IDX_W'(0);
      else                             idx_d = idx_q + IDX_W'(1);
    end else begin
      bv_d = 1'b0;
    end
  end

  always_comb begin
    lvl_nxt_s = level;
    if (push_s && !pop_s)      lvl_nxt_s = level + LVL_W'(1);
    else if (pop_s && !push_s) lvl_nxt_s = level - LVL_W'(1);
    else                       lvl_nxt_s = level;
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q <= W_IDLE;
      rdrst_q <= 1'b0;
      ovf_q   <= 16'd0;
      afull_q <= 1'b0;
      div_q   <= DIV_W'(0);
      idx_q   <= IDX_W'(0);
      sh_q    <= DATA_W'(0);
      bout_q  <= 1'b0;
      bv_q    <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdrst_q <= (state_d == W_CLR);
      ovf_q   <= ovf_d;
      afull_q <= (32'(lvl_nxt_s) >= AFULL_LVL);
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      bout_q  <= bout_d;
      bv_q    <= bv_d;
      fill_q  <= fill_d;
    end
  end

  assign rdrst     = rdrst_q;
  assign bit_out   = bout_q;
  assign bit_valid = bv_q;
  assign bit_fill  = fill_q;
  assign full      = fifo_full_s;
  assign empty     = fifo_empty_s;
  assign afull     = afull_q;
  assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_tlm_bitbuf.sv
// Bench for tlm_bitbuf: two instances (LSB-first and MSB-first) share one stimulus and
// are compared every cycle against a queue-based model, plus directed literal checks.
module tb_tlm_bitbuf;

  localparam int         DW    = 8;
  localparam int         DEPTH = 4;
  localparam int         DIV   = 4;
  localparam int         AF    = 3;
  localparam logic [7:0] IDLE  = 8'h7E;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdrdy = 1'b0;
  logic       fill_en = 1'b0;
  logic [7:0] rbr = 8'h00;

  logic       rdrst_l, bit_out_l, bit_valid_l, bit_fill_l, full_l, empty_l, afull_l;
  logic       rdrst_m, bit_out_m, bit_valid_m, bit_fill_m, full_m, empty_m, afull_m;
  logic [2:0] level_l, level_m;
  logic [15:0] ovf_l, ovf_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlm_bitbuf #(.DATA_W(DW), .DEPTH_W(DEPTH), .CLK_DIV(DIV), .LSB_FIRST(1), .AFULL_LVL(AF)) dut_l (
    .clk_100M(clk), .rst(rst), .rbr(rbr), .rdrdy(rdrdy), .rdrst(rdrst_l), .fill_en(fill_en),
    .bit_out(bit_out_l), .bit_valid(bit_valid_l), .bit_fill(bit_fill_l), .level(level_l),
    .full(full_l), .empty(empty_l), .afull(afull_l), .ovf_cnt(ovf_l));

  tlm_bitbuf #(.DATA_W(DW), .DEPTH_W(DEPTH), .CLK_DIV(DIV), .LSB_FIRST(0), .AFULL_LVL(AF)) dut_m (
    .clk_100M(clk), .rst(rst), .rbr(rbr), .rdrdy(rdrdy), .rdrst(rdrst_m), .fill_en(fill_en),
    .bit_out(bit_out_m), .bit_valid(bit_valid_m), .bit_fill(bit_fill_m), .level(level_m),
    .full(full_m), .empty(empty_m), .afull(afull_m), .ovf_cnt(ovf_m));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  q[$];
  logic [7:0]  cur = 8'h00;
  int          cyc = 0;
  int          idx = 0;
  bit          cap = 1'b0, clr = 1'b0, fillw = 1'b0, mdl_ready = 1'b0;
  logic        e_rdrst = 1'b0, e_bv = 1'b0, e_bl = 1'b0, e_bm = 1'b0;
  logic [15:0] e_ovf = 16'd0;

  task automatic model_step();
    bit tick, have;
    if (rst) begin
      q.delete();
      cyc = 0; idx = 0; cap = 1'b0; clr = 1'b0; fillw = 1'b0;
      e_rdrst = 1'b0; e_bv = 1'b0; e_bl = 1'b0; e_bm = 1'b0; e_ovf = 16'd0;
      mdl_ready = 1'b1;
    end else begin
      tick = ((cyc % DIV) == DIV - 1);
      cyc++;
      e_bv = 1'b0;
      have = 1'b0;
      if (tick) begin
        if (idx == 0) begin
          if (q.size() > 0) begin
            cur = q.pop_front(); fillw = 1'b0; have = 1'b1;
          end else if (fill_en) begin
            cur = IDLE; fillw = 1'b1; have = 1'b1;
          end
        end else begin
          have = 1'b1;
        end
        if (have) begin
          e_bv = 1'b1;
          e_bl = cur[idx];
          e_bm = cur[DW-1-idx];
          idx  = (idx + 1) % DW;
        end
      end
      // receiver handshake: capture one edge after rdrdy seen, then wait for rdrdy low
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(rbr);
        else if (e_ovf != 16'hFFFF) e_ovf++;
        cap = 1'b0;
        clr = 1'b1;
      end else if (clr) begin
        if (!rdrdy) clr = 1'b0;
      end else if (rdrdy) begin
        cap = 1'b1;
      end
      e_rdrst = clr;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process and bit monitor ----------------
  logic lq[$], mq[$], fq[$];
  int   tq[$];
  int   ncyc = 0;

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (bit_valid_l === 1'b1) begin
      lq.push_back(bit_out_l);
      mq.push_back(bit_out_m);
      fq.push_back(bit_fill_l);
      tq.push_back(ncyc);
    end
    if (mdl_ready) begin
      check("rdrst_l", rdrst_l, e_rdrst);
      check("rdrst_m", rdrst_m, e_rdrst);
      check("bit_valid_l", bit_valid_l, e_bv);
      check("bit_valid_m", bit_valid_m, e_bv);
      check("bit_out_l", bit_out_l, e_bl);
      check("bit_out_m", bit_out_m, e_bm);
      check("bit_fill_l", bit_fill_l, fillw);
      check("bit_fill_m", bit_fill_m, fillw);
      check("level_l", level_l, 32'(q.size()));
      check("level_m", level_m, 32'(q.size()));
      check("full_l", full_l, q.size() == DEPTH);
      check("full_m", full_m, q.size() == DEPTH);
      check("empty_l", empty_l, q.size() == 0);
      check("empty_m", empty_m, q.size() == 0);
      check("afull_l", afull_l, q.size() >= AF);
      check("afull_m", afull_m, q.size() >= AF);
      check("ovf_l", ovf_l, e_ovf);
      check("ovf_m", ovf_m, e_ovf);
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] pack_lsb(input logic qq[$], input int s);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) if (s + i < qq.size()) r[i] = qq[s+i];
    return r;
  endfunction

  function automatic logic [7:0] pack_msb(input logic qq[$], input int s);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) if (s + i < qq.size()) r[7-i] = qq[s+i];
    return r;
  endfunction

  task automatic clear_mon();
    lq.delete(); mq.delete(); fq.delete(); tq.delete();
  endtask

  task automatic wait_rdrst(input logic lvl, input string name);
    int n;
    n = 0;
    while (rdrst_l !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, rdrst_l, lvl);
  endtask

  task automatic send_word(input logic [7:0] w, input int hold);
    @(negedge clk);
    rbr   = w;
    rdrdy = 1'b1;
    wait_rdrst(1'b1, "hs_ack");
    repeat (hold) @(negedge clk);
    rdrdy = 1'b0;
    wait_rdrst(1'b0, "hs_release");
  endtask

  task automatic wait_bits(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (lq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, lq.size() >= n, 1'b1);
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [7:0] ovw [7];
  int         nbv, nchg;
  logic       b0l, b0m;

  initial begin
    ovw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    repeat (3) @(negedge clk);
    check("rst_level", level_l, 32'd0);
    check("rst_empty", empty_l, 1'b1);
    check("rst_full", full_l, 1'b0);
    check("rst_afull", afull_l, 1'b0);
    check("rst_ovf", ovf_l, 32'd0);
    check("rst_rdrst", rdrst_l, 1'b0);
    check("rst_bv", bit_valid_l, 1'b0);
    check("rst_bout", bit_out_l, 1'b0);
    check("rst_fill", bit_fill_l, 1'b0);
    rst = 1'b0;

    // single word A5, both orders
    clear_mon();
    send_word(8'hA5, 0);
    wait_bits(8, 80, "a5_bits");
    check("a5_seq_lsb", pack_msb(lq, 0), 8'b10100101);
    check("a5_word_lsb", pack_lsb(lq, 0), 8'hA5);
    check("a5_word_msb", pack_msb(mq, 0), 8'hA5);
    check("a5_spacing", tq[7] - tq[0], 32'd28);
    check("a5_fill", fq[0], 1'b0);
    check("a5_empty", empty_l, 1'b1);

    // asymmetric word 01
    clear_mon();
    send_word(8'h01, 0);
    wait_bits(8, 80, "w01_bits");
    check("w01_seq_lsb", pack_msb(lq, 0), 8'b10000000);
    check("w01_seq_msb", pack_msb(mq, 0), 8'b00000001);

    // overflow burst with fill disabled
    clear_mon();
    for (int i = 0; i < 7; i++) send_word(ovw[i], 0);
    check("ovf_level", level_l, 32'd4);
    check("ovf_full", full_l, 1'b1);
    check("ovf_afull", afull_l, 1'b1);
    check("ovf_cnt", ovf_l, 32'd2);
    wait_bits(40, 250, "ovf_bits");
    for (int k = 0; k < 5; k++) begin
      check("ovf_word_lsb", pack_lsb(lq, 8 * k), ovw[k]);
      check("ovf_word_msb", pack_msb(mq, 8 * k), ovw[k]);
    end
    repeat (4) @(negedge clk);
    check("ovf_drained", empty_l, 1'b1);

    // idle fill, data arriving mid fill word
    clear_mon();
    fill_en = 1'b1;
    wait_bits(2, 40, "fill_start");
    send_word(8'h3C, 0);
    wait_bits(16, 100, "fill_bits");
    fill_en = 1'b0;
    check("fill_word", pack_lsb(lq, 0), IDLE);
    check("fill_word_msb", pack_msb(mq, 0), IDLE);
    check("fill_flag0", fq[0], 1'b1);
    check("fill_flag7", fq[7], 1'b1);
    check("fill_data", pack_lsb(lq, 8), 8'h3C);
    check("fill_data_msb", pack_msb(mq, 8), 8'h3C);
    check("fill_flag8", fq[8], 1'b0);
    repeat (40) @(negedge clk);

    // stall: empty, fill disabled
    nbv = 0; nchg = 0;
    b0l = bit_out_l; b0m = bit_out_m;
    repeat (40) begin
      @(negedge clk);
      if (bit_valid_l || bit_valid_m) nbv++;
      if (bit_out_l !== b0l || bit_out_m !== b0m) nchg++;
    end
    check("stall_bv", nbv, 32'd0);
    check("stall_hold", nchg, 32'd0);

    // reset with words queued and a word mid-serialisation
    send_word(8'hC3, 0);
    send_word(8'h96, 0);
    send_word(8'h0F, 0);
    send_word(8'hF0, 0);
    check("mid_level", level_l, 32'd3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_level", level_l, 32'd0);
    check("mid_rst_bv", bit_valid_l, 1'b0);
    check("mid_rst_rdrst", rdrst_l, 1'b0);
    check("mid_rst_ovf", ovf_l, 32'd0);

    // reset while the handshake holds rdrst; the held word is captured again
    @(negedge clk);
    rbr = 8'h5A; rdrdy = 1'b1;
    wait_rdrst(1'b1, "clr_ack");
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("clr_rst_rdrst", rdrst_l, 1'b0);
    check("clr_rst_level", level_l, 32'd0);
    clear_mon();
    wait_rdrst(1'b1, "clr_reack");
    rdrdy = 1'b0;
    wait_rdrst(1'b0, "clr_release");
    wait_bits(8, 80, "clr_bits");
    check("clr_word", pack_lsb(lq, 0), 8'h5A);
    check("clr_word_msb", pack_msb(mq, 0), 8'h5A);

    // randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      fill_en = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
      send_word(8'($urandom), $urandom_range(0, 3));
    end
    fill_en = 1'b0;
    repeat (150) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
